// File: rtl/zverif_ctrl_responder.sv
// Write-only AXI4-Lite responder for the 16-byte control window: register 0 feeds a
// console byte FIFO, register 1 latches a sticky exit code, registers 2/3 answer SLVERR.

module zverif_ctrl_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [7:0]             i_push_data,
  input  logic                   i_pop,
  output logic [7:0]             o_head,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

  logic [7:0]     r_mem [DEPTH];
  logic [PTR_W:0] r_wr_cnt;
  logic [PTR_W:0] r_rd_cnt;

  logic [PTR_W:0] w_level;
  logic           w_do_push;
  logic           w_do_pop;

  // Counters carry one extra bit so full and empty stay distinguishable after wrap.
  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign o_level   = w_level;
  assign o_valid   = (w_level != '0);
  assign o_full    = (w_level == FULL_LVL);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && o_valid;
  assign o_head    = r_mem[r_rd_cnt[PTR_W-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_cnt[PTR_W-1:0]] <= i_push_data;
        r_wr_cnt                   <= r_wr_cnt + CNT_ONE;
      end
      if (w_do_pop) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
    end
  end

endmodule

module zverif_ctrl_responder #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            ctrl_awaddr,
  input  logic                   ctrl_awvalid,
  output logic                   ctrl_awready,
  input  logic [31:0]            ctrl_wdata,
  input  logic                   ctrl_wvalid,
  output logic                   ctrl_wready,
  output logic                   ctrl_bvalid,
  input  logic                   ctrl_bready,
  output logic [1:0]             ctrl_bresp,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   exit_valid,
  output logic [31:0]            exit_code
);

  localparam logic [1:0] IDX_TX      = 2'd0;
  localparam logic [1:0] IDX_EXIT    = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_w_held;
  logic [31:0]           r_wdata;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_exit_valid;
  logic [31:0]           r_exit_code;

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic [1:0] w_idx;
  logic       w_fifo_full;
  logic       w_commit;
  logic       w_push;
  logic       w_unused;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender keeps valid and its payload steady until then, and ready never depends
  // combinationally on valid. Each channel here has a one-entry hold, so ready is simply
  // "hold empty"; B is raised by this block and held until the master's bready.
  assign ctrl_awready = !r_aw_held;
  assign ctrl_wready  = !r_w_held;
  assign ctrl_bvalid  = r_bvalid;
  assign ctrl_bresp   = r_bresp;
  assign exit_valid   = r_exit_valid;
  assign exit_code    = r_exit_code;

  assign w_aw_hs = ctrl_awvalid && !r_aw_held;
  assign w_w_hs  = ctrl_wvalid && !r_w_held;
  assign w_b_hs  = r_bvalid && ctrl_bready;
  assign w_idx   = r_awaddr[3:2];

  // A console write into a full FIFO waits in the holds; the registered full flag is used,
  // so a pop in the same cycle only frees the slot for the next cycle.
  assign w_commit = r_aw_held && r_w_held && !r_bvalid &&
                    !((w_idx == IDX_TX) && w_fifo_full);
  assign w_push   = w_commit && (w_idx == IDX_TX);

  assign w_unused = &{1'b0, ctrl_awaddr[31:ADDR_WIDTH], r_awaddr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
    end else if (w_aw_hs) begin
      r_aw_held <= 1'b1;
      r_awaddr  <= ctrl_awaddr[ADDR_WIDTH-1:0];
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_w_held <= 1'b0;
      r_wdata  <= '0;
    end else if (w_w_hs) begin
      r_w_held <= 1'b1;
      r_wdata  <= ctrl_wdata;
    end else if (w_commit) begin
      r_w_held <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= ((w_idx == IDX_TX) || (w_idx == IDX_EXIT)) ? RESP_OKAY : RESP_SLVERR;
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end
  end

  // Only the first exit write is kept; the simulation harness reads the earliest code.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exit_valid <= 1'b0;
      r_exit_code  <= '0;
    end else if (w_commit && (w_idx == IDX_EXIT) && !r_exit_valid) begin
      r_exit_valid <= 1'b1;
      r_exit_code  <= r_wdata;
    end
  end

  zverif_ctrl_fifo #(
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_push_data (r_wdata[7:0]),
    .i_pop       (tx_ready),
    .o_head      (tx_data),
    .o_valid     (tx_valid),
    .o_full      (w_fifo_full),
    .o_level     (tx_level)
  );

endmodule
